// File: rtl/pipe_pkg.sv
// +------------------------------------------------------------------+
// | pipe_pkg : shared types and defaults for the elastic pipe stage   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  localparam int PIPE_DEF_WIDTH = 32;
  localparam int PIPE_DEF_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// +------------------------------------------------------------------+
// | sat_counter : saturating event counter with synchronous clear     |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sat_counter
  import pipe_pkg::*;
#(
  parameter int CNT_W = PIPE_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over increment; the all-ones value sticks instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// +------------------------------------------------------------------+
// | pipe_stage_elastic : valid/ready pipeline register with flush and |
// | stall counter. PIPE_SKID_BUFFER_EN selects the two-entry skid.    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int WIDTH = PIPE_DEF_WIDTH,
  parameter int CNT_W = PIPE_DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_cnt_clr
);

  pipe_state_t      state_q;
  pipe_state_t      state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] main_d;
  logic             in_acc;
  logic             out_acc;

  assign out_valid = (state_q != EMPTY);
  assign out_data  = main_q;
  assign in_acc    = in_valid && in_ready;
  assign out_acc   = out_valid && out_ready;

`ifdef PIPE_SKID_BUFFER_EN
  logic [WIDTH-1:0] skid_q;
  logic [WIDTH-1:0] skid_d;
  logic             in_ready_q;

  assign in_ready = in_ready_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_acc && out_acc) begin
            main_d = in_data;
          end else if (in_acc) begin
            state_d = FULL;
            skid_d  = in_data;
          end else if (out_acc) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (out_acc) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Ready is computed from the next state so it never depends on out_ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  // An accept while holding a beat implies the head leaves in the same cycle.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_acc) begin
            state_d = ONE;
            main_d  = in_data;
          end
        end
        ONE: begin
          if (in_acc) begin
            main_d = in_data;
          end else if (out_acc) begin
            state_d = EMPTY;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
    end
  end
`endif

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid && !out_ready),
    .clr   (stall_cnt_clr),
    .count (stall_cnt)
  );

endmodule

`default_nettype wire

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised successor to the plain enable/clear pipeline flop.
- Elastic valid/ready pipeline stage register for the MIPS datapath (IF/ID, ID/EX, EX/MEM, MEM/WB boundaries).
- Replaces global stall/clear wiring with per-stage handshakes, a synchronous flush and a saturating stall-cycle counter for performance analysis.

Parameters:
- WIDTH, 32, payload width in bits (full stage bundle).
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = asserted.
- flush  in  1  synchronous squash of all held beats.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  stage can accept a beat.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a valid beat.
- out_ready  in  1  downstream accepts.
- out_data  out  WIDTH  payload of the head beat.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- stall_cnt_clr  in  1  synchronous counter clear.

Behaviour:
- Reset (reset==0, asynchronous):
  - state=EMPTY, main/skid data=0, out_valid=0, out_data=0, stall_cnt=0, in_ready=1.
  - Handshakes are ignored while reset is asserted.
- Transfers: upstream accept when in_valid&&in_ready; downstream accept when out_valid&&out_ready.
- Latency: a beat accepted at edge N appears on out_data with out_valid=1 immediately after edge N.
- Ordering: strictly FIFO; no beat is ever duplicated or dropped except by flush.
- out_data and out_valid are stable while out_valid&&!out_ready.
- in_valid may drop without acceptance; the stage must not depend on upstream holding it.
- State machine (with skid, see Optional Feature):
  - EMPTY: accept -> ONE (main<=in_data).
  - ONE, in-accept and out-accept -> ONE (main<=in_data).
  - ONE, in-accept only -> FULL (skid<=in_data).
  - ONE, out-accept only -> EMPTY.
  - ONE, neither -> ONE.
  - FULL: in_ready=0; out-accept -> ONE (main<=skid). Otherwise hold.
  - in_ready is registered: 1 iff next state != FULL. There is no combinational path out_ready->in_ready.
- Flush:
  - Priority below reset, above all handshakes.
  - Next state=EMPTY; main and skid data<=0; any beat offered in the flush cycle is dropped.
  - A downstream accept in the flush cycle still counts as a completed transfer.
  - in_ready=1 after the flush edge.
- Stall counter:
  - Increments each cycle out_valid&&!out_ready, saturating at 2^CNT_W-1 (no wrap).
  - stall_cnt_clr has priority over increment and yields 0 next cycle.
  - flush does not affect the counter.
- Reset mid-transfer: all beats are lost; no partial state survives.

Optional Feature:
- Macro: PIPE_SKID_BUFFER_EN.
- Defined: two-entry skid operation with the EMPTY/ONE/FULL state machine above. Registered in_ready gives full throughput with no ready combinational path.
- Undefined:
  - Single entry; states EMPTY/ONE only; skid register absent.
  - in_ready = !out_valid || out_ready (combinational). Throughput is still 1 beat/cycle.
  - Flush, counter and reset behaviour are unchanged.

Decomposition:
- Package pipe_pkg: state enum pipe_state_t {EMPTY, ONE, FULL}; constants PIPE_DEF_WIDTH=32, PIPE_DEF_CNT_W=16.
- Sub-module sat_counter (parameter CNT_W; inputs inc, clr; output count; saturating) for the stall counter. Reusable for other performance counters.

Test Plan:
- Reset then stream 0x11,0x22,0x33 with out_ready=1 -> out_data 0x11,0x22,0x33 on consecutive cycles, each one cycle after accept; stall_cnt=0.
- Accept 0xA1, hold out_ready=0, offer 0xA2 then 0xA3 (skid) -> 0xA2 accepted; in_ready=0 next cycle; 0xA3 held upstream. Raise out_ready -> 0xA1,0xA2,0xA3 in order; stall_cnt equals the number of stalled cycles.
- In FULL state assert flush with in_valid=1 (0xBB) -> out_valid=0, out_data=0, in_ready=1 next cycle; 0xBB never appears.
- Hold out_valid=1, out_ready=0 with CNT_W=4 for 20 cycles -> stall_cnt saturates at 15. Pulse stall_cnt_clr -> 0, then increments resume.
- Assert reset=0 asynchronously mid-cycle while in ONE -> out_valid, out_data, stall_cnt drop to 0 without waiting for clk; in_ready=1.
- Build without PIPE_SKID_BUFFER_EN; toggle out_ready randomly -> in_ready tracks !out_valid||out_ready in the same cycle; payload order preserved.
